// File: rtl/pcihellocore_pio_pkg.sv
// Shared definitions for the PCI hello-core PIO blocks: register map, CTRL bit
// positions and the pulse timer state encoding.
package pcihellocore_pio_pkg;

  localparam logic [1:0] ADDR_DATA      = 2'd0;
  localparam logic [1:0] ADDR_PULSE_LEN = 2'd1;
  localparam logic [1:0] ADDR_SETCLR    = 2'd2;
  localparam logic [1:0] ADDR_CTRL      = 2'd3;

  localparam int unsigned CTRL_PULSE_EN = 0;
  localparam int unsigned CTRL_IRQ_EN   = 1;
  localparam int unsigned CTRL_DONE     = 2;
  localparam int unsigned CTRL_BUSY     = 3;

  typedef enum logic {
    IDLE,
    ACTIVE
  } pulse_state_e;

endpackage

// File: rtl/pcihellocore_pulse_timer.sv
// Pulse length timer: counts down a loaded value and flags expiry when it
// runs out. A load always wins over abort, disable and expiry.
module pcihellocore_pulse_timer
  import pcihellocore_pio_pkg::*;
#(
  parameter int unsigned LEN_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_load,
  input  logic [LEN_WIDTH-1:0] i_load_val,
  input  logic                 i_enable,
  input  logic                 i_abort,
  output logic                 o_expire,
  output logic                 o_busy
);

  pulse_state_e         r_state;
  pulse_state_e         w_state_next;
  logic [LEN_WIDTH-1:0] r_count;
  logic [LEN_WIDTH-1:0] w_count_next;

  // State and counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_count <= '0;
    end else begin
      r_state <= w_state_next;
      r_count <= w_count_next;
    end
  end

  // Next-state, countdown and expiry strobe.
  always_comb begin
    w_state_next = r_state;
    w_count_next = r_count;
    o_expire     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (i_load) begin
          w_state_next = ACTIVE;
          w_count_next = i_load_val;
        end
      end
      ACTIVE: begin
        if (i_load) begin
          w_count_next = i_load_val;
        end else if (i_abort || !i_enable) begin
          // Cancelled pulse: leave quietly, no expiry.
          w_state_next = IDLE;
          w_count_next = '0;
        end else if (r_count == '0) begin
          o_expire     = 1'b1;
          w_state_next = IDLE;
        end else begin
          w_count_next = r_count - 1'b1;
        end
      end
      default: begin
        w_state_next = IDLE;
        w_count_next = '0;
      end
    endcase
  end

  assign o_busy = (r_state == ACTIVE);

endmodule

// File: rtl/pcihellocore_led_out.sv
// Avalon-MM output PIO: static DATA writes, atomic set/clear, and a timed
// pulse mode that auto-clears the port and raises a sticky DONE/irq.
module pcihellocore_led_out
  import pcihellocore_pio_pkg::*;
#(
  parameter int unsigned    WIDTH       = 16,
  parameter int unsigned    LEN_WIDTH   = 16,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port,
  output logic             irq
);

  logic [WIDTH-1:0]     r_data;
  logic [LEN_WIDTH-1:0] r_pulse_len;
  logic                 r_pulse_en;
  logic                 r_irq_en;
  logic                 r_done;
  logic [31:0]          r_readdata;

  logic                 w_wr;
  logic                 w_data_wr;
  logic                 w_ctrl_wr;
  logic [WIDTH-1:0]     w_data_new;
  logic                 w_pulse_en_next;
  logic                 w_load;
  logic                 w_abort;
  logic                 w_expire;
  logic                 w_busy;
  logic [31:0]          w_rd_mux;

  assign w_wr      = chipselect & ~write_n;
  assign w_data_wr = w_wr & ((address == ADDR_DATA) || (address == ADDR_SETCLR));
  assign w_ctrl_wr = w_wr & (address == ADDR_CTRL);

  // Value DATA would take from a DATA or SETCLR write (clear beats set).
  always_comb begin
    w_data_new = r_data;
    if (address == ADDR_DATA) begin
      w_data_new = writedata[WIDTH-1:0];
    end else begin
      w_data_new = (r_data | writedata[WIDTH-1:0]) & ~writedata[16 +: WIDTH];
    end
  end

  // The timer sees the post-write PULSE_EN so disabling cancels on the same edge.
  assign w_pulse_en_next = w_ctrl_wr ? writedata[CTRL_PULSE_EN] : r_pulse_en;
  assign w_load  = w_data_wr & r_pulse_en & (r_pulse_len != '0) & (w_data_new != '0);
  assign w_abort = w_data_wr & ~w_load;

  pcihellocore_pulse_timer #(
    .LEN_WIDTH (LEN_WIDTH)
  ) u_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_load     (w_load),
    .i_load_val (r_pulse_len - LEN_WIDTH'(1)),
    .i_enable   (w_pulse_en_next),
    .i_abort    (w_abort),
    .o_expire   (w_expire),
    .o_busy     (w_busy)
  );

  // Register file updates; DONE set beats a same-edge write-1-to-clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data      <= RESET_VALUE;
      r_pulse_len <= '0;
      r_pulse_en  <= 1'b0;
      r_irq_en    <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      if (w_data_wr) begin
        r_data <= w_data_new;
      end else if (w_expire) begin
        r_data <= '0;
      end
      if (w_wr && (address == ADDR_PULSE_LEN)) begin
        r_pulse_len <= writedata[LEN_WIDTH-1:0];
      end
      if (w_ctrl_wr) begin
        r_pulse_en <= writedata[CTRL_PULSE_EN];
        r_irq_en   <= writedata[CTRL_IRQ_EN];
      end
      if (w_expire) begin
        r_done <= 1'b1;
      end else if (w_ctrl_wr && writedata[CTRL_DONE]) begin
        r_done <= 1'b0;
      end
    end
  end

  // Read mux over pre-write register values.
  always_comb begin
    w_rd_mux = '0;
    unique case (address)
      ADDR_DATA:      w_rd_mux = 32'(r_data);
      ADDR_PULSE_LEN: w_rd_mux = 32'(r_pulse_len);
      ADDR_SETCLR:    w_rd_mux = '0;
      ADDR_CTRL: begin
        w_rd_mux[CTRL_PULSE_EN] = r_pulse_en;
        w_rd_mux[CTRL_IRQ_EN]   = r_irq_en;
        w_rd_mux[CTRL_DONE]     = r_done;
        w_rd_mux[CTRL_BUSY]     = w_busy;
      end
      default:        w_rd_mux = '0;
    endcase
  end

  // Read data is captured every cycle regardless of chipselect.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_readdata <= '0;
    end else begin
      r_readdata <= w_rd_mux;
    end
  end

  assign readdata = r_readdata;
  assign out_port = r_data;
  assign irq      = r_done & r_irq_en;

endmodule

// File: tb/tb_pcihellocore_led_out.sv
// Directed bench for pcihellocore_led_out: register access, SETCLR, pulse
// timing, retrigger, same-edge expiry/write and asynchronous reset.
module tb_pcihellocore_led_out;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [15:0] out_port;
  logic        irq;

  int n_vec;
  int n_err;

  pcihellocore_led_out dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One-cycle write; returns 1ns after the accepting edge.
  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  // One-cycle read; checks readdata 1ns after the capturing edge.
  task automatic bus_rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
    @(negedge clk);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    chk(tag, readdata, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec      = 0;
    n_err      = 0;
    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out", 32'(out_port), 32'h0);
    chk("rst_rd", readdata, 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // Static DATA write and readback; same-edge read sees old value.
    bus_wr(2'd0, 32'h0000_A5A5);
    chk("data_out", 32'(out_port), 32'h0000_A5A5);
    chk("data_rd_prewrite", readdata, 32'h0);
    bus_rd("data_rd", 2'd0, 32'h0000_A5A5);

    // SETCLR: set bits 1:0, clear bit 4; then clear-over-set on bit 0.
    bus_wr(2'd0, 32'h0000_00F0);
    bus_wr(2'd2, 32'h0010_0003);
    chk("setclr_out", 32'(out_port), 32'h0000_00E3);
    bus_rd("setclr_rd", 2'd2, 32'h0);
    bus_wr(2'd2, 32'h0001_0001);
    chk("setclr_prio", 32'(out_port), 32'h0000_00E2);

    // Pulse of length 5.
    bus_wr(2'd1, 32'd5);
    bus_rd("plen_rd", 2'd1, 32'd5);
    bus_wr(2'd3, 32'h3);
    bus_wr(2'd0, 32'h1);
    chk("pulse5_e0", 32'(out_port), 32'h1);
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk($sformatf("pulse5_e%0d", k), 32'(out_port), (k < 5) ? 32'h1 : 32'h0);
    end
    chk("pulse5_irq", 32'(irq), 32'h1);
    bus_rd("pulse5_ctrl", 2'd3, 32'h7);
    bus_wr(2'd3, 32'h7);
    chk("w1c_irq", 32'(irq), 32'h0);
    bus_rd("w1c_ctrl", 2'd3, 32'h3);

    // Retrigger: length 4, rewrite DATA two edges after the start.
    bus_wr(2'd1, 32'd4);
    bus_wr(2'd0, 32'h1);
    tick();
    chk("retrig_e1", 32'(out_port), 32'h1);
    bus_wr(2'd0, 32'h2);
    chk("retrig_r0", 32'(out_port), 32'h2);
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk($sformatf("retrig_r%0d", k), 32'(out_port), (k < 4) ? 32'h2 : 32'h0);
      chk($sformatf("retrig_irq%0d", k), 32'(irq), (k < 4) ? 32'h0 : 32'h1);
    end
    bus_rd("retrig_ctrl", 2'd3, 32'h7);
    bus_wr(2'd3, 32'h7);

    // Expiry and DATA write on the same edge: write wins, no DONE.
    bus_wr(2'd1, 32'd1);
    bus_wr(2'd0, 32'h1);
    bus_wr(2'd0, 32'h4);
    chk("conflict_out", 32'(out_port), 32'h4);
    chk("conflict_irq", 32'(irq), 32'h0);
    tick();
    chk("conflict_exp", 32'(out_port), 32'h0);
    chk("conflict_irq2", 32'(irq), 32'h1);
    bus_wr(2'd3, 32'h7);

    // SETCLR clearing to zero mid-pulse cancels without DONE.
    bus_wr(2'd1, 32'd3);
    bus_wr(2'd0, 32'h1);
    bus_wr(2'd2, 32'h0001_0000);
    chk("cancel_out", 32'(out_port), 32'h0);
    repeat (4) tick();
    chk("cancel_irq", 32'(irq), 32'h0);
    bus_rd("cancel_ctrl", 2'd3, 32'h3);

    // PULSE_LEN=0 with PULSE_EN=1: static.
    bus_wr(2'd1, 32'd0);
    bus_wr(2'd0, 32'h0000_FFFF);
    repeat (20) tick();
    chk("static_out", 32'(out_port), 32'h0000_FFFF);
    bus_rd("static_ctrl", 2'd3, 32'h3);

    // Asynchronous reset in the middle of a pulse.
    bus_wr(2'd1, 32'd10);
    bus_wr(2'd0, 32'h8);
    chk("arst_pre", 32'(out_port), 32'h8);
    repeat (3) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_out", 32'(out_port), 32'h0);
    chk("arst_irq", 32'(irq), 32'h0);
    chk("arst_rd", readdata, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    bus_rd("arst_ctrl", 2'd3, 32'h0);
    bus_rd("arst_plen", 2'd1, 32'h0);
    repeat (12) tick();
    chk("arst_irq_late", 32'(irq), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pcihellocore_led_out.md
# pcihellocore_led_out

Avalon-MM slave output port that drives a parallel `out_port` (LEDs, relays, strobes) from the PCI host, complementing the core's input PIOs. It sits on the same Avalon interconnect as the button/switch inputs. The host controls it through the same 2-bit word-address, registered-read protocol. Besides static writes, it provides atomic set/clear and a timed pulse mode: the port auto-clears after a programmable cycle count and raises a sticky done flag and interrupt.

## Interface
- `WIDTH`, 16, output port width (1..16)
- `LEN_WIDTH`, 16, pulse length counter width
- `RESET_VALUE`, 0, `out_port` value after reset
- `clk`  in  1  clock
- `reset_n`  in  1  reset, asynchronous, active-low
- `address`  in  2  word address
- `chipselect`  in  1  slave select
- `write_n`  in  1  active-low write strobe; write accepted when `chipselect & ~write_n`
- `writedata`  in  32  write data
- `readdata`  out  32  registered read data
- `out_port`  out  WIDTH  driven output (registered)
- `irq`  out  1  `DONE & IRQ_EN`

## Operation
- Address 0, DATA (RW): write sets `data = writedata[WIDTH-1:0]`; read returns zero-extended `data`.
- Address 1, PULSE_LEN (RW): `LEN_WIDTH` bits; read zero-extended.
- Address 2, SETCLR (W, reads 0): `data = (data | writedata[WIDTH-1:0]) & ~writedata[16+WIDTH-1:16]`. Clear has priority over set on the same bit.
- Address 3, CTRL:
  - bit0 PULSE_EN (RW)
  - bit1 IRQ_EN (RW)
  - bit2 DONE (R; write 1 clears)
  - bit3 BUSY (RO, state==ACTIVE)
  - other bits read 0.
- State machine, states IDLE and ACTIVE:
  - IDLE→ACTIVE: a DATA or SETCLR write while `PULSE_EN=1` and `PULSE_LEN≠0` whose resulting `data≠0`. Counter loads `PULSE_LEN-1`.
  - ACTIVE with counter>0: decrement.
  - ACTIVE with counter==0: `data←0`, DONE←1, go IDLE.
  - DATA/SETCLR write in ACTIVE: counter reloads from current PULSE_LEN. If the resulting data is 0, go IDLE without setting DONE.
  - Writing PULSE_EN=0 in ACTIVE: go IDLE; data is kept, DONE is not set.
- `PULSE_LEN=0` with PULSE_EN=1: no auto-clear (static behaviour).
- A PULSE_LEN write during ACTIVE does not affect the running pulse.
- `out_port = data` at all times.

## Timing
- Reset values:
  - `data=RESET_VALUE`, PULSE_LEN=0, CTRL=0, state IDLE, counter 0
  - outputs: `readdata=0`, `out_port=RESET_VALUE`, `irq=0`.
- A write accepted at edge E is visible on `out_port` and registers after E.
- Read latency is 1 cycle. `readdata` is registered every cycle from `address`, independent of chipselect. A read in the same cycle as a write returns the pre-write value.
- Pulse: a triggering write at edge E0 makes `out_port` nonzero for exactly PULSE_LEN cycles; it clears at edge E0+PULSE_LEN.
- Same-edge conflicts:
  - Expiry + DATA/SETCLR write: the write wins, the timer reloads, no DONE.
  - DONE set + W1C of DONE: set wins.
- `irq` is combinational from registered DONE/IRQ_EN, so it asserts the cycle after expiry.
- Reset asserted mid-pulse returns all state to reset values immediately (asynchronous); no DONE is generated.

## Structure
- Package `pcihellocore_pio_pkg` contains:
  - address constants `ADDR_DATA/ADDR_PULSE_LEN/ADDR_SETCLR/ADDR_CTRL`
  - CTRL bit indices
  - state enum `{IDLE, ACTIVE}`.
- Sub-module `pcihellocore_pulse_timer`:
  - ports: load, load value, enable, abort
  - outputs: `expire`, `busy`
  - owns the counter and the state machine.
- The top level holds the register file, SETCLR logic, and read mux.

## Test plan
- Reset → `out_port=0`, `readdata=0`, `irq=0`. Write DATA=0xA5A5, then read address 0 → `out_port=0xA5A5` one edge after the write; `readdata=0x0000A5A5` one cycle after the read.
- DATA=0x00F0, then SETCLR write `0x0010_0003` → `out_port=0x00E3`; read address 2 → 0.
- PULSE_LEN=5, CTRL=0x3, then DATA=0x0001 → `out_port=1` for exactly 5 cycles, then 0. CTRL reads 0x7 (DONE, IRQ_EN, PULSE_EN), `irq=1`. Write CTRL=0x7 → `irq=0`, DONE=0.
- PULSE_LEN=4, pulse started, rewrite DATA=0x0002 on the 3rd cycle → `out_port=2` for 4 cycles from the rewrite; only one DONE.
- PULSE_LEN=0, PULSE_EN=1, DATA=0xFFFF → held indefinitely, BUSY=0. Then PULSE_LEN=10, DATA=0x0008; drop `reset_n` at cycle 3 → `out_port=0` and CTRL=0 immediately, `irq=0`.
